fa_fault_detector: RTL and testbench
====================================

// Module: fa_fault_detector
// PURPOSE
//  Detects and classifies stuck-at faults on a 1-bit full adder under test (CUT).
//  On start, it drives all 8 input vectors {a,b,cin} into the CUT and samples sum/carry.
//  It compares the samples against golden patterns and reports a fault code.
//  The code uses the same encoding as the fault-injection selector (0 none, 1-4 stuck-at).
//  Sits beside the fault-injecting adder in the fault-detection testbed.
// PARAMETERS
//  SETTLE_CYCLES  1  cycles each vector is held before sampling; legal range 1..15
// PORTS
//  clk             in   1  single clock; all state changes on rising edge
//  rst             in   1  synchronous, active-high reset
//  start           in   1  request a test run; accepted only in IDLE
//  cut_a           out  1  vector bit a to CUT
//  cut_b           out  1  vector bit b to CUT
//  cut_cin         out  1  vector bit cin to CUT
//  cut_sum         in   1  CUT sum output
//  cut_carry       in   1  CUT carry output
//  busy            out  1  high while a run is in progress (RUN or CLASSIFY)
//  done            out  1  one-cycle pulse when results become valid
//  fault_detected  out  1  1 = any mismatch seen in last run
//  fault_code      out  3  0 none, 1 sum s-a-0, 2 sum s-a-1, 3 carry s-a-0, 4 carry s-a-1, 7 unclassified
//  mismatch_count  out  4  number of vectors (0..8) where sum or carry mismatched
// BEHAVIOUR
//  Reset:
//   - All outputs 0, state IDLE.
//   - Internal vec, settle counter and observation registers cleared.
//  FSM IDLE -> RUN -> CLASSIFY -> DONE -> IDLE.
//  IDLE:
//   - start=1 -> RUN; vec=0, cnt=0, sum_obs/carry_obs cleared.
//   - Results of the previous run are cleared on this transition.
//  RUN:
//   - {cut_a,cut_b,cut_cin} = vec[2:0], driven from registers.
//   - cnt increments every cycle.
//   - When cnt==SETTLE_CYCLES-1:
//     - sum_obs[vec] <= cut_sum, carry_obs[vec] <= cut_carry.
//     - cnt <= 0, vec <= vec+1.
//     - If vec==7 -> CLASSIFY.
//  CLASSIFY (1 cycle):
//   - Compare sum_obs against 8'h96 and carry_obs against 8'hE8.
//   - Bit i of each pattern is the golden value for vec=i.
//   - Register fault_detected, fault_code and mismatch_count, then go to DONE.
//  DONE (1 cycle): done=1, then IDLE.
//  Latency: done is high exactly 8*SETTLE_CYCLES+2 cycles after the edge that sampled start.
//  Classification:
//   - se = sum_obs!=96, ce = carry_obs!=E8.
//   - !se & !ce -> 0.
//   - se & !ce: sum_obs==00 -> 1, sum_obs==FF -> 2, else 7.
//   - ce & !se: carry_obs==00 -> 3, carry_obs==FF -> 4, else 7.
//   - se & ce -> 7.
//   - mismatch_count = popcount((sum_obs^96)|(carry_obs^E8)).
//   - fault_detected = se|ce.
//  Result outputs hold from DONE until the next accepted start or reset.
//  Boundaries:
//   - start while busy or in DONE is ignored, with no queueing.
//   - rst mid-RUN aborts the run immediately: outputs 0, no done pulse.
//   - rst has priority over start in the same cycle.
//   - The vec counter never wraps inside a run; it stops at 7.
//   - cut_* hold their last vector (7) after RUN until the next run starts.
// STRUCTURE
//  Package fa_fault_pkg:
//   - localparams GOLD_SUM=8'h96, GOLD_CARRY=8'hE8.
//   - Fault-code constants FC_NONE=0, FC_SUM_SA0=1, FC_SUM_SA1=2, FC_CARRY_SA0=3, FC_CARRY_SA1=4, FC_UNKNOWN=7.
//   - State encoding typedef.
//   - The fault-injection block uses the same fault-code constants.
//  Sub-module fa_fault_classifier:
//   - Purely combinational.
//   - Inputs sum_obs[7:0] and carry_obs[7:0]; outputs code[2:0], detected, count[3:0].
//   - Registered by the parent in CLASSIFY.
// TESTING (CUT = fault-injecting adder, its selector driven by the bench)
//  1. sel=0, start -> done at cycle 10 (SETTLE=1), fault_code=0, detected=0, count=0.
//  2. sel=1 -> code 1, count 4. sel=2 -> code 2, count 4.
//  3. sel=3 -> code 3, count 4. sel=4 -> code 4, count 4. Back-to-back runs, results update each run.
//  4. SETTLE_CYCLES=3, sel=0 -> done exactly 26 cycles after start. cut_* sequence 0..7, each held 3 cycles.
//  5. start pulsed again during RUN -> ignored, exactly one done pulse. rst at RUN cycle 4 -> all outputs 0, no done.
//  6. Bench forces cut_sum=~golden_sum (carry correct) -> code 7, count 8, detected=1.

Source files
------------

// File: rtl/fa_fault_pkg.sv
// Shared constants, fault codes and state encoding for the full-adder fault detector.
// The fault-injecting adder uses the same fault-code values.
package fa_fault_pkg;

   localparam logic [7:0] GOLD_SUM   = 8'h96;
   localparam logic [7:0] GOLD_CARRY = 8'hE8;

   localparam logic [2:0] FC_NONE      = 3'd0;
   localparam logic [2:0] FC_SUM_SA0   = 3'd1;
   localparam logic [2:0] FC_SUM_SA1   = 3'd2;
   localparam logic [2:0] FC_CARRY_SA0 = 3'd3;
   localparam logic [2:0] FC_CARRY_SA1 = 3'd4;
   localparam logic [2:0] FC_UNKNOWN   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_CLASSIFY = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/fa_fault_classifier.sv
// Combinational classifier: maps observed sum/carry truth tables to a fault code,
// a detected flag and the number of mismatching vectors.
module fa_fault_classifier
   import fa_fault_pkg::*;
(
   input  logic [7:0] sum_obs,
   input  logic [7:0] carry_obs,
   output logic [2:0] code,
   output logic       detected,
   output logic [3:0] count
);

   logic sum_err_s;
   logic carry_err_s;

   assign sum_err_s   = (sum_obs != GOLD_SUM);
   assign carry_err_s = (carry_obs != GOLD_CARRY);
   assign detected    = sum_err_s | carry_err_s;
   assign count       = popcount8((sum_obs ^ GOLD_SUM) | (carry_obs ^ GOLD_CARRY));

   // A single stuck-at fault shows as one output pinned to all-0 or all-1.
   always_comb begin
      code = FC_NONE;
      if (sum_err_s && carry_err_s) begin
         code = FC_UNKNOWN;
      end else if (sum_err_s) begin
         if (sum_obs == 8'h00) begin
            code = FC_SUM_SA0;
         end else if (sum_obs == 8'hFF) begin
            code = FC_SUM_SA1;
         end else begin
            code = FC_UNKNOWN;
         end
      end else if (carry_err_s) begin
         if (carry_obs == 8'h00) begin
            code = FC_CARRY_SA0;
         end else if (carry_obs == 8'hFF) begin
            code = FC_CARRY_SA1;
         end else begin
            code = FC_UNKNOWN;
         end
      end else begin
         code = FC_NONE;
      end
   end

endmodule

// File: rtl/fa_fault_detector.sv
// Exhaustive 8-vector test of a 1-bit full adder under test, with stuck-at
// classification of the sampled sum/carry responses.
module fa_fault_detector
   import fa_fault_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       cut_a,
   output logic       cut_b,
   output logic       cut_cin,
   input  logic       cut_sum,
   input  logic       cut_carry,
   output logic       busy,
   output logic       done,
   output logic       fault_detected,
   output logic [2:0] fault_code,
   output logic [3:0] mismatch_count
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state_q,     state_d;
   logic [2:0] vec_q,       vec_d;
   logic [3:0] cnt_q,       cnt_d;
   logic [7:0] sum_obs_q,   sum_obs_d;
   logic [7:0] carry_obs_q, carry_obs_d;
   logic       busy_q,      busy_d;
   logic       done_q,      done_d;
   logic       det_q,       det_d;
   logic [2:0] code_q,      code_d;
   logic [3:0] count_q,     count_d;

   logic [2:0] cls_code_s;
   logic       cls_det_s;
   logic [3:0] cls_count_s;

   fa_fault_classifier u_classifier (
      .sum_obs   (sum_obs_q),
      .carry_obs (carry_obs_q),
      .code      (cls_code_s),
      .detected  (cls_det_s),
      .count     (cls_count_s)
   );

   // Next-state and output logic for the test sequencer.
   always_comb begin
      state_d     = state_q;
      vec_d       = vec_q;
      cnt_d       = cnt_q;
      sum_obs_d   = sum_obs_q;
      carry_obs_d = carry_obs_q;
      det_d       = det_q;
      code_d      = code_q;
      count_d     = count_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_RUN;
               vec_d       = 3'd0;
               cnt_d       = 4'd0;
               sum_obs_d   = 8'h00;
               carry_obs_d = 8'h00;
               det_d       = 1'b0;
               code_d      = FC_NONE;
               count_d     = 4'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cnt_q == SETTLE_LAST) begin
               sum_obs_d[vec_q]   = cut_sum;
               carry_obs_d[vec_q] = cut_carry;
               cnt_d              = 4'd0;
               // vec parks at 7 so the CUT keeps seeing the last vector.
               if (vec_q == 3'd7) begin
                  state_d = ST_CLASSIFY;
               end else begin
                  vec_d = vec_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_CLASSIFY: begin
            det_d   = cls_det_s;
            code_d  = cls_code_s;
            count_d = cls_count_s;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_RUN) || (state_d == ST_CLASSIFY);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         vec_q       <= 3'd0;
         cnt_q       <= 4'd0;
         sum_obs_q   <= 8'h00;
         carry_obs_q <= 8'h00;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         det_q       <= 1'b0;
         code_q      <= FC_NONE;
         count_q     <= 4'd0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         cnt_q       <= cnt_d;
         sum_obs_q   <= sum_obs_d;
         carry_obs_q <= carry_obs_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         det_q       <= det_d;
         code_q      <= code_d;
         count_q     <= count_d;
      end
   end

   assign cut_a          = vec_q[2];
   assign cut_b          = vec_q[1];
   assign cut_cin        = vec_q[0];
   assign busy           = busy_q;
   assign done           = done_q;
   assign fault_detected = det_q;
   assign fault_code     = code_q;
   assign mismatch_count = count_q;

endmodule

// File: tb/tb_fa_fault_detector.sv
// Bench: two detector instances (settle 1 and 3) driving bench-side fault-injecting adders.
module tb_fa_fault_detector;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start1, start3;
   logic       a1, b1, c1, sum1, carry1, busy1, done1, det1;
   logic [2:0] code1;
   logic [3:0] cnt1;
   logic       a3, b3, c3, sum3, carry3, busy3, done3, det3;
   logic [2:0] code3;
   logic [3:0] cnt3;

   logic [2:0] sel;
   logic [7:0] smask, cmask;
   logic [2:0] idx1;
   logic       s_g1, c_g1;

   int errors = 0;
   int checks = 0;

   fa_fault_detector #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1),
      .cut_a(a1), .cut_b(b1), .cut_cin(c1), .cut_sum(sum1), .cut_carry(carry1),
      .busy(busy1), .done(done1), .fault_detected(det1),
      .fault_code(code1), .mismatch_count(cnt1)
   );

   fa_fault_detector #(.SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3),
      .cut_a(a3), .cut_b(b3), .cut_cin(c3), .cut_sum(sum3), .cut_carry(carry3),
      .busy(busy3), .done(done3), .fault_detected(det3),
      .fault_code(code3), .mismatch_count(cnt3)
   );

   // Fault-injecting adder: selector stuck-ats plus per-vector flip masks.
   assign idx1 = {a1, b1, c1};
   always_comb begin
      s_g1 = a1 ^ b1 ^ c1;
      c_g1 = (a1 & b1) | (a1 & c1) | (b1 & c1);
      case (sel)
         3'd1:    s_g1 = 1'b0;
         3'd2:    s_g1 = 1'b1;
         3'd3:    c_g1 = 1'b0;
         3'd4:    c_g1 = 1'b1;
         default: ;
      endcase
      sum1   = s_g1 ^ smask[idx1];
      carry1 = c_g1 ^ cmask[idx1];
   end

   assign sum3   = a3 ^ b3 ^ c3;
   assign carry3 = (a3 & b3) | (a3 & c3) | (b3 & c3);

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: build the observed truth tables arithmetically, then apply the classification rules.
   function automatic void ref_model(input int s, input logic [7:0] sm, input logic [7:0] cm,
                                     output int code, output int det, output int cnt);
      int a, b, c, tot, sb, cb, so, co, gs, gc;
      so = 0; co = 0; gs = 0; gc = 0; cnt = 0;
      for (int i = 0; i < 8; i++) begin
         a = (i >> 2) & 1; b = (i >> 1) & 1; c = i & 1;
         tot = a + b + c;
         sb = tot % 2; cb = tot / 2;
         if (s == 1) sb = 0;
         if (s == 2) sb = 1;
         if (s == 3) cb = 0;
         if (s == 4) cb = 1;
         sb = sb ^ int'(sm[i]);
         cb = cb ^ int'(cm[i]);
         if (sb != tot % 2 || cb != tot / 2) cnt++;
         so += sb << i; co += cb << i;
         gs += (tot % 2) << i; gc += (tot / 2) << i;
      end
      det = (so != gs || co != gc) ? 1 : 0;
      if (so != gs && co != gc) code = 7;
      else if (so != gs) code = (so == 0) ? 1 : (so == 255) ? 2 : 7;
      else if (co != gc) code = (co == 0) ? 3 : (co == 255) ? 4 : 7;
      else code = 0;
   endfunction

   task automatic run1(input string name, input int ecode, input int edet, input int ecnt);
      int k;
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      check({name, " busy"}, busy1, 1);
      k = 0;
      while (k < 60 && !done1) begin
         @(negedge clk); k++;
      end
      check({name, " latency"}, k, 10);
      check({name, " code"}, code1, ecode);
      check({name, " detected"}, det1, edet);
      check({name, " count"}, cnt1, ecnt);
      @(negedge clk);
      check({name, " done width"}, done1, 0);
      check({name, " idle busy"}, busy1, 0);
      check({name, " cut hold"}, {a1, b1, c1}, 7);
   endtask

   typedef struct {
      logic [2:0] sel;
      logic [7:0] sm;
      logic [7:0] cm;
      int         code;
      int         det;
      int         cnt;
   } vec_t;

   vec_t tv[6];

   initial begin
      int k, pulses, first, rcode, rdet, rcnt;
      tv[0] = '{3'd0, 8'h00, 8'h00, 0, 0, 0};
      tv[1] = '{3'd1, 8'h00, 8'h00, 1, 1, 4};
      tv[2] = '{3'd2, 8'h00, 8'h00, 2, 1, 4};
      tv[3] = '{3'd3, 8'h00, 8'h00, 3, 1, 4};
      tv[4] = '{3'd4, 8'h00, 8'h00, 4, 1, 4};
      tv[5] = '{3'd0, 8'hFF, 8'h00, 7, 1, 8};

      rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
      sel = 3'd0; smask = 8'h00; cmask = 8'h00;
      repeat (3) @(negedge clk);
      check("reset busy", busy1, 0);
      check("reset done", done1, 0);
      check("reset code", code1, 0);
      check("reset det", det1, 0);
      check("reset count", cnt1, 0);
      check("reset cut", {a1, b1, c1}, 0);
      check("reset busy3", busy3, 0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         sel = tv[i].sel; smask = tv[i].sm; cmask = tv[i].cm;
         run1($sformatf("tv%0d", i), tv[i].code, tv[i].det, tv[i].cnt);
      end
      repeat (5) @(negedge clk);
      check("hold code", code1, 7);
      check("hold det", det1, 1);
      check("hold count", cnt1, 8);

      for (int r = 0; r < 20; r++) begin
         sel   = 3'($urandom_range(0, 4));
         smask = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
         cmask = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
         ref_model(int'(sel), smask, cmask, rcode, rdet, rcnt);
         run1($sformatf("rnd%0d", r), rcode, rdet, rcnt);
      end

      // start pulsed again mid-run must be ignored.
      sel = 3'd1; smask = 8'h00; cmask = 8'h00;
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      pulses = 0; first = -1;
      for (k = 1; k <= 40; k++) begin
         @(negedge clk);
         start1 = (k == 3) ? 1'b1 : 1'b0;
         if (done1) begin
            pulses++;
            if (first < 0) first = k;
         end
      end
      start1 = 1'b0;
      check("restart pulses", pulses, 1);
      check("restart latency", first, 10);
      check("restart code", code1, 1);

      // Reset mid-run aborts with no done.
      sel = 3'd4;
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      repeat (4) @(negedge clk);
      check("pre-abort busy", busy1, 1);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check("abort busy", busy1, 0);
      check("abort done", done1, 0);
      check("abort code", code1, 0);
      check("abort det", det1, 0);
      check("abort count", cnt1, 0);
      check("abort cut", {a1, b1, c1}, 0);
      pulses = 0;
      repeat (20) begin
         @(negedge clk);
         if (done1) pulses++;
      end
      check("abort no done", pulses, 0);

      // Reset wins over a simultaneous start.
      rst = 1'b1; start1 = 1'b1;
      @(negedge clk); rst = 1'b0; start1 = 1'b0;
      @(negedge clk);
      check("rst over start busy", busy1, 0);

      // Settle=3: each vector held three cycles, done 26 cycles after start.
      @(negedge clk); start3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
      k = 0;
      while (k < 60 && !done3) begin
         check($sformatf("s3 cut k%0d", k), {a3, b3, c3}, (k < 24) ? k / 3 : 7);
         @(negedge clk); k++;
      end
      check("s3 latency", k, 26);
      check("s3 code", code3, 0);
      check("s3 det", det3, 0);
      check("s3 count", cnt3, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
